// File: rtl/filter_line_packer_if.sv
// Payload bus between filter_line_packer and the UDP transmitter core.
// pack_req/pack_len/pack_data are driven by the packer (master);
// pack_ack/pack_rd_en are driven by the UDP core (slave).
interface filter_line_packer_if;
    logic        pack_req;    // level: a complete line is ready
    logic [15:0] pack_len;    // header + line bytes, stable while pack_req
    logic        pack_ack;    // one-cycle accept pulse
    logic        pack_rd_en;  // one byte per strobe
    logic [7:0]  pack_data;   // byte for the strobe of the previous cycle

    modport master (
        output pack_req,
        output pack_len,
        output pack_data,
        input  pack_ack,
        input  pack_rd_en
    );

    modport slave (
        input  pack_req,
        input  pack_len,
        input  pack_data,
        output pack_ack,
        output pack_rd_en
    );
endinterface

// File: rtl/filter_line_packer.sv
// Packs filter lines into ping-pong line buffers and serves each as a UDP payload (4-byte header + bytes).
// Latency: href_end at t -> pack_req at t+2; pack_data one cycle after each accepted pack_rd_en.
// Backpressure: none on the filter side; a line arriving with both banks full is dropped (line_drop).
//
// Ports: clk, rst (async, active-high); filter_data/filter_en/filter_pic_start/filter_first_href/
//        filter_href_end from the filter; line_drop pulse; pack (master modport) towards the UDP core.
module filter_line_packer #(
    parameter int MAX_BYTES = 2048,
    parameter int AW        = 11
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  filter_data,
    input  logic                        filter_en,
    input  logic                        filter_pic_start,
    input  logic                        filter_first_href,
    input  logic                        filter_href_end,
    output logic                        line_drop,
    filter_line_packer_if.master        pack
);
    // wr_cnt needs one extra bit so it can hold MAX_BYTES when saturated
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    logic [7:0]    mem [2][MAX_BYTES];

    logic [7:0]    frame_cnt;
    logic [15:0]   line_num;
    logic [CW-1:0] wr_cnt;
    logic          wr_bank;
    logic          in_line;    // first filter_en of the current line already seen
    logic          dropping;   // current line is being discarded
    logic [1:0]    full;
    logic [CW-1:0] bank_len   [2];
    logic [15:0]   bank_line  [2];
    logic [7:0]    bank_frame [2];

    logic [1:0]    state;
    logic          rd_bank;
    logic [15:0]   rd_idx;
    logic [7:0]    hdr_frame;
    logic [15:0]   hdr_line;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_byte;

    // First-line marker is informational only
    logic          first_href_unused;
    assign first_href_unused = filter_first_href;

    // The drop decision is taken once, at the first byte of a line
    logic drop_now, wr_fire, href_ok, queue_line, rd_fire;
    logic [1:0] set_mask, clr_mask;

    assign drop_now   = filter_en && !in_line && (full == 2'b11) && !filter_pic_start;
    assign wr_fire    = filter_en && !filter_pic_start && !dropping && !drop_now && (wr_cnt < MAX_CNT);
    assign href_ok    = filter_href_end && !filter_pic_start;
    assign queue_line = href_ok && !dropping && (wr_cnt != '0);
    assign line_drop  = href_ok && dropping;

    // Write and release always hit different banks: a non-dropped line is
    // only ever written into a bank that was empty at its first byte.
    assign set_mask = queue_line ? (2'b01 << wr_bank) : 2'b00;
    assign clr_mask = (state == S_REL) ? (2'b01 << rd_bank) : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            line_num  <= '0;
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            in_line   <= 1'b0;
            dropping  <= 1'b0;
            full      <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                bank_len[b]   <= '0;
                bank_line[b]  <= '0;
                bank_frame[b] <= '0;
            end
        end else begin
            full <= (full | set_mask) & ~clr_mask;
            if (filter_pic_start) begin
                // A new frame abandons any partial line; queued banks survive
                frame_cnt <= frame_cnt + 8'd1;
                line_num  <= '0;
                wr_cnt    <= '0;
                in_line   <= 1'b0;
                dropping  <= 1'b0;
            end else begin
                if (filter_en) in_line <= 1'b1;
                if (drop_now) dropping <= 1'b1;
                if (wr_fire) wr_cnt <= wr_cnt + 1'b1;
                if (filter_href_end) begin
                    line_num <= line_num + 16'd1;
                    in_line  <= 1'b0;
                    dropping <= 1'b0;
                    if (queue_line) begin
                        bank_len[wr_bank]   <= wr_cnt;
                        bank_line[wr_bank]  <= line_num;
                        bank_frame[wr_bank] <= frame_cnt;
                        wr_bank             <= ~wr_bank;
                        wr_cnt              <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_bank][wr_cnt[AW-1:0]] <= filter_data;
    end

    // Payload index 0..3 is the header, the rest maps onto the buffer
    assign rd_addr = rd_idx[AW-1:0] - AW'(4);

    always_comb begin
        case (rd_idx)
            16'd0:   rd_byte = 8'hA5;
            16'd1:   rd_byte = hdr_frame;
            16'd2:   rd_byte = hdr_line[15:8];
            16'd3:   rd_byte = hdr_line[7:0];
            default: rd_byte = mem[rd_bank][rd_addr];
        endcase
    end

    assign pack.pack_req = (state == S_REQ);
    assign rd_fire       = (state == S_SEND) && pack.pack_rd_en && (rd_idx < pack.pack_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            rd_bank        <= 1'b0;
            rd_idx         <= '0;
            hdr_frame      <= '0;
            hdr_line       <= '0;
            pack.pack_len  <= '0;
            pack.pack_data <= '0;
        end else begin
            // Strobes outside SEND or past the payload read back as zero
            pack.pack_data <= rd_fire ? rd_byte : 8'h00;
            case (state)
                S_IDLE: begin
                    // Banks fill alternately, so rd_bank is always the oldest
                    if (full[rd_bank]) begin
                        pack.pack_len <= 16'(bank_len[rd_bank]) + 16'd4;
                        hdr_frame     <= bank_frame[rd_bank];
                        hdr_line      <= bank_line[rd_bank];
                        rd_idx        <= '0;
                        state         <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (pack.pack_ack) state <= S_SEND;
                end
                S_SEND: begin
                    if (rd_fire) begin
                        rd_idx <= rd_idx + 16'd1;
                        if (rd_idx + 16'd1 == pack.pack_len) state <= S_REL;
                    end
                end
                S_REL: begin
                    rd_bank <= ~rd_bank;
                    state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_filter_line_packer.sv
module tb_filter_line_packer;
    localparam int MAX_BYTES = 2048;
    localparam int AW        = 11;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] filter_data;
    logic       filter_en, filter_pic_start, filter_first_href, filter_href_end;
    logic       line_drop;

    filter_line_packer_if pk();

    filter_line_packer #(.MAX_BYTES(MAX_BYTES), .AW(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .filter_data       (filter_data),
        .filter_en         (filter_en),
        .filter_pic_start  (filter_pic_start),
        .filter_first_href (filter_first_href),
        .filter_href_end   (filter_href_end),
        .line_drop         (line_drop),
        .pack              (pk)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: frame/line counters, queued payloads, banks in use
    logic [7:0]  m_frame = 8'd0;
    logic [15:0] m_line  = 16'd0;
    int          outstanding = 0;
    int          exp_len[$];
    logic [7:0]  exp_bytes[$];

    bit manual = 1'b1;  // main process drives the pack bus itself
    bit hold   = 1'b0;  // consumer withholds pack_ack

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_byte(input string name);
        logic [7:0] e;
        if (exp_bytes.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: got 0x%02h with no expected byte queued", name, pk.pack_data);
        end else begin
            e = exp_bytes.pop_front();
            check(name, {24'd0, pk.pack_data}, {24'd0, e});
        end
    endtask

    task automatic pic_start();
        filter_pic_start = 1'b1;
        tick();
        filter_pic_start = 1'b0;
        m_frame = m_frame + 8'd1;
        m_line  = 16'd0;
    endtask

    // Sends one line of n bytes (pattern base+i, or random when base<0)
    task automatic send_line(input int n, input int base);
        logic [7:0] d;
        logic [7:0] kept[$];
        bit drop;
        drop = 1'b0;
        filter_first_href = (m_line == 16'd0);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) == 0) begin
                filter_en = 1'b0;
                tick();
            end
            if (i == 0) drop = (outstanding >= 2);
            d = (base >= 0) ? 8'(base + i) : 8'($urandom);
            filter_en   = 1'b1;
            filter_data = d;
            if (!drop && i < MAX_BYTES) kept.push_back(d);
            tick();
        end
        filter_en       = 1'b0;
        filter_href_end = 1'b1;
        #1;
        check("line_drop", {31'd0, line_drop}, {31'd0, drop && n > 0});
        tick();
        filter_href_end   = 1'b0;
        filter_first_href = 1'b0;
        if (!drop && n > 0) begin
            exp_len.push_back(kept.size() + 4);
            exp_bytes.push_back(8'hA5);
            exp_bytes.push_back(m_frame);
            exp_bytes.push_back(m_line[15:8]);
            exp_bytes.push_back(m_line[7:0]);
            foreach (kept[k]) exp_bytes.push_back(kept[k]);
            outstanding++;
        end
        m_line = m_line + 16'd1;
    endtask

    task automatic partial_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            filter_en   = 1'b1;
            filter_data = 8'($urandom);
            tick();
        end
        filter_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        while ((outstanding != 0 || exp_len.size() != 0) && budget > 0) begin
            tick();
            budget--;
        end
        check("drain_outstanding", outstanding, 0);
    endtask

    task automatic wait_slot(input int budget);
        while (outstanding >= 2 && budget > 0) begin
            tick();
            budget--;
        end
        check("slot_free", {31'd0, outstanding < 2}, 32'd1);
    endtask

    // Handshake driven from the main process; reads nread bytes back-to-back
    task automatic manual_read(input int nread);
        int budget;
        int len;
        budget = 50;
        while (!pk.pack_req && budget > 0) begin
            tick();
            budget--;
        end
        check("manual_req", {31'd0, pk.pack_req}, 32'd1);
        len = (exp_len.size() != 0) ? exp_len.pop_front() : 0;
        check("manual_len", {16'd0, pk.pack_len}, len);
        pk.pack_ack = 1'b1;
        tick();
        pk.pack_ack = 1'b0;
        check("manual_req_fall", {31'd0, pk.pack_req}, 32'd0);
        for (int i = 0; i < nread; i++) begin
            pk.pack_rd_en = 1'b1;
            tick();
            pk.pack_rd_en = 1'b0;
            check_byte("manual_data");
        end
    endtask

    // Monitor / UDP-core model: acks queued payloads and checks every byte
    initial begin : consumer
        int len;
        int ext;
        forever begin
            tick();
            if (!manual && !hold && pk.pack_req) begin
                len = (exp_len.size() != 0) ? exp_len.pop_front() : 0;
                check("pack_len", {16'd0, pk.pack_len}, len);
                pk.pack_ack = 1'b1;
                tick();
                pk.pack_ack = 1'b0;
                check("req_after_ack", {31'd0, pk.pack_req}, 32'd0);
                for (int i = 0; i < len; i++) begin
                    repeat ($urandom_range(1) * $urandom_range(2)) tick();
                    pk.pack_rd_en = 1'b1;
                    tick();
                    pk.pack_rd_en = 1'b0;
                    check_byte("pack_data");
                end
                ext = $urandom_range(3);
                for (int i = 0; i < ext; i++) begin
                    pk.pack_rd_en = 1'b1;
                    tick();
                    pk.pack_rd_en = 1'b0;
                    check("extra_rd_zero", {24'd0, pk.pack_data}, 32'd0);
                end
                repeat (2) tick();
                outstanding--;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst = 1'b1;
        filter_data = '0;
        filter_en = 1'b0;
        filter_pic_start = 1'b0;
        filter_first_href = 1'b0;
        filter_href_end = 1'b0;
        pk.pack_ack = 1'b0;
        pk.pack_rd_en = 1'b0;
        repeat (3) tick();
        check("rst_req",  {31'd0, pk.pack_req},  32'd0);
        check("rst_len",  {16'd0, pk.pack_len},  32'd0);
        check("rst_data", {24'd0, pk.pack_data}, 32'd0);
        check("rst_drop", {31'd0, line_drop},    32'd0);
        rst = 1'b0;
        tick();

        // Single line: exact request latency, header, trailing strobes
        pic_start();
        send_line(8, 'h10);
        check("req_t_plus1", {31'd0, pk.pack_req}, 32'd0);
        tick();
        check("req_t_plus2", {31'd0, pk.pack_req}, 32'd1);
        check("len_single", {16'd0, pk.pack_len}, 32'd12);
        manual_read(12);
        for (int i = 0; i < 3; i++) begin
            pk.pack_rd_en = 1'b1;
            tick();
            pk.pack_rd_en = 1'b0;
            check("manual_extra_zero", {24'd0, pk.pack_data}, 32'd0);
        end
        repeat (2) tick();
        outstanding--;
        manual = 1'b0;

        // Both banks full, third line dropped
        hold = 1'b1;
        pic_start();
        send_line(640, -1);
        send_line(640, -1);
        send_line(640, -1);
        hold = 1'b0;
        wait_drain(8000);

        // Truncation at MAX_BYTES
        send_line(MAX_BYTES + 5, -1);
        wait_drain(12000);

        // Partial line aborted by pic_start, then pic_start coinciding with href_end
        pic_start();
        partial_bytes(100);
        pic_start();
        partial_bytes(30);
        filter_pic_start = 1'b1;
        filter_href_end  = 1'b1;
        #1;
        check("drop_on_pic_href", {31'd0, line_drop}, 32'd0);
        tick();
        filter_pic_start = 1'b0;
        filter_href_end  = 1'b0;
        m_frame = m_frame + 8'd1;
        m_line  = 16'd0;
        send_line(20, 'h80);
        wait_drain(1000);

        // Frame counter wrap 255 -> 0
        while (m_frame != 8'd255) pic_start();
        send_line(6, 'h30);
        pic_start();
        send_line(6, 'h50);
        wait_drain(1000);

        // Randomised lines, ping-pong with a free-running consumer
        for (int l = 0; l < 16; l++) begin
            if ($urandom_range(4) == 0) pic_start();
            wait_slot(3000);
            send_line($urandom_range(300), -1);
        end
        wait_drain(6000);

        // Reset in the middle of a payload
        manual = 1'b1;
        send_line(16, 'h40);
        manual_read(5);
        rst = 1'b1;
        pk.pack_rd_en = 1'b1;
        #1;
        check("midrst_req",  {31'd0, pk.pack_req},  32'd0);
        check("midrst_len",  {16'd0, pk.pack_len},  32'd0);
        check("midrst_data", {24'd0, pk.pack_data}, 32'd0);
        tick();
        rst = 1'b0;
        pk.pack_rd_en = 1'b0;
        exp_len.delete();
        exp_bytes.delete();
        outstanding = 0;
        m_frame = 8'd0;
        m_line  = 16'd0;
        manual = 1'b0;
        tick();
        send_line(10, 'h60);
        wait_drain(1000);
        check("leftover_bytes", exp_bytes.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/filter_line_packer.md
# filter_line_packer

Line-buffered packetiser that sits after the 3x3 gray filter stage and feeds the UDP transmitter. It takes the filter byte stream (two bytes per pixel) and its frame/line markers, stores each finished line in one of two ping-pong line buffers, and delivers it as one UDP payload. Each payload is a 4-byte header followed by the line bytes, read out by the UDP core through a request/acknowledge/read-strobe handshake.

## Interface
- MAX_BYTES, 2048, capacity of each line buffer in bytes; max payload bytes per line
- AW, 11, address width of the line buffers; 2**AW >= MAX_BYTES
- clk  in  1  pixel/system clock, all logic on rising edge
- rst  in  1  reset; one clock, asynchronous, active-high
- filter_data  in  8  filtered byte
- filter_en  in  1  filter_data valid this cycle
- filter_pic_start  in  1  frame start pulse
- filter_first_href  in  1  high during first line of frame; informational, not used for control
- filter_href_end  in  1  one-cycle pulse after the last byte of a line
- pack_req  out  1  level: a complete line is ready to send
- pack_len  out  16  total payload bytes = 4 + line byte count; stable while pack_req=1
- pack_ack  in  1  one-cycle pulse from the UDP core accepting the request
- pack_rd_en  in  1  read strobe, one byte per cycle
- pack_data  out  8  payload byte, valid the cycle after pack_rd_en
- line_drop  out  1  one-cycle pulse when an incoming line is discarded

## Operation
- Counters:
  - frame_cnt[7:0] increments on filter_pic_start and wraps 255->0.
  - line_num[15:0] clears on filter_pic_start and increments on every filter_href_end.
- Write side:
  - On filter_en, the byte goes to the active write bank at wr_cnt, and wr_cnt increments.
  - wr_cnt saturates at MAX_BYTES. Bytes beyond that are dropped and the line is still queued, truncated.
  - On filter_href_end with wr_cnt>0:
    - Latch bank_len = wr_cnt, bank_line = line_num and bank_frame = frame_cnt.
    - Mark the bank full, switch to the other bank, clear wr_cnt.
  - On filter_href_end with wr_cnt=0, nothing is queued.
- Overflow: if both banks are full when a line's first filter_en arrives, the whole line is discarded.
  - No writes occur and no bank is marked.
  - line_drop pulses once, at the href_end of that line.
  - line_num still increments.
- filter_pic_start discards the partial line in the write bank (wr_cnt<=0). Full banks are unaffected.
- Read FSM, states IDLE, REQ, SEND, REL:
  - IDLE: if the oldest full bank exists, load pack_len and the header, then go to REQ.
  - REQ: pack_req=1. On pack_ack go to SEND, with pack_req low the next cycle.
  - SEND: each pack_rd_en returns byte rd_idx on the next cycle, then rd_idx increments.
    - Header bytes: 0: 8'hA5, 1: bank_frame, 2: bank_line[15:8], 3: bank_line[7:0].
    - Bytes 4.. come from buffer address rd_idx-4.
    - When rd_idx reaches pack_len, go to REL.
  - REL: free the bank, switch the read bank, return to IDLE.
- pack_rd_en outside SEND, or beyond pack_len, is ignored and pack_data is 0.
- Banks are served strictly in fill order.

## Timing
- Reset values: pack_req=0, pack_len=0, pack_data=0, line_drop=0. Both banks empty, frame_cnt=0, line_num=0, FSM in IDLE.
- href_end at cycle t makes the bank full at t+1; IDLE raises pack_req at t+2 at the earliest.
- pack_ack while pack_req=0 is ignored.
- pack_ack at cycle t: first pack_rd_en accepted at t+1 or later.
- pack_data latency is exactly 1 cycle after pack_rd_en. Back-to-back strobes give back-to-back bytes.
- Bank freed at REL, one cycle after the last byte is read. A line ending in that same cycle sees the bank as still full.
- Simultaneous filter_pic_start and filter_href_end: pic_start wins, the line is discarded, line_num=0.
- A write and a read never target the same bank.
- rst mid-send: all state clears immediately and the in-flight packet is abandoned.

## Test plan
- Single line, pic_start then 8 filter_en bytes 0x10..0x17 then href_end, ack, 12 strobes -> pack_len=12; data A5,01,00,00,10..17; pack_req falls after ack.
- Two lines, 640 bytes each, ack withheld -> second line fills the other bank. A third line -> line_drop pulse at its href_end, no write. After draining, line_num in headers reads 0 then 1.
- Line of MAX_BYTES+5 bytes -> pack_len=MAX_BYTES+4; last data byte equals byte MAX_BYTES-1 of input.
- pic_start midway through a 100-byte line -> no packet for it; next line header has frame_cnt+1 and line 0.
- 3 extra pack_rd_en after pack_len bytes -> pack_data=0 and no bank-state change. 256 frames -> frame_cnt wraps to 0.
- rst asserted during SEND at byte 5 -> outputs 0 immediately; next line is sent normally with header line 0.
